// File: rtl/simasm_pkg.sv
// Shared definitions for the SimASM data-memory path: bus widths common to
// DataMemory, Controller and the port arbiter, plus the arbiter owner encoding.
package simasm_pkg;

    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the debug port has lost arbitration.
// Clear has priority over increment; sat is high once the count reaches MAX.
module arb_starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = (count >= W'(MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port DataMemory between the CPU and a debug/loader port.
// Registered owner selection; read data returns the cycle after the access.
module dm_port_arbiter
    import simasm_pkg::*;
#(
    parameter int ADDR_W     = DM_ADDR_W,
    parameter int DATA_W     = DM_DATA_W,
    parameter int STARVE_MAX = 4,
    // 0 lets a requester win consecutive cycles (bring-up harnesses only)
    parameter bit SELF_EXCL  = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    // Handshake: a requester raises req with we/addr/wdata and holds them all
    // until it sees gnt, which pulses during the one cycle the access is made.
    owner_t          owner;
    owner_t          pick;
    owner_t          resp;
    logic            cpu_elig;
    logic            dbg_elig;
    logic [SW-1:0]   starve;
    logic            starve_sat;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    always_comb begin
        cpu_elig = cpu_req && !(SELF_EXCL && (owner == OWN_CPU));
        dbg_elig = dbg_req && !(SELF_EXCL && (owner == OWN_DBG));
        pick     = OWN_NONE;
        if (cpu_elig && !starve_sat) begin
            pick = OWN_CPU;
        end else if (dbg_elig) begin
            pick = OWN_DBG;
        end else if (cpu_elig) begin
            pick = OWN_CPU;
        end
    end

    arb_starve_counter #(
        .MAX (STARVE_MAX),
        .W   (SW)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .clr   (pick == OWN_DBG),
        .inc   (dbg_req && (pick != OWN_DBG)),
        .count (starve),
        .sat   (starve_sat)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= OWN_NONE;
            resp        <= OWN_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            owner <= pick;
            if (owner == OWN_CPU && !cpu_we) begin
                resp <= OWN_CPU;
            end else if (owner == OWN_DBG && !dbg_we) begin
                resp <= OWN_DBG;
            end else begin
                resp <= OWN_NONE;
            end
            if (resp == OWN_CPU) cpu_rdata_q <= mem_q;
            if (resp == OWN_DBG) dbg_rdata_q <= mem_q;
        end
    end

    // Outputs are forced idle while reset is high so an in-flight response is dropped.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (!reset && owner == OWN_CPU) begin
            mem_address = cpu_addr;
            mem_data    = cpu_wdata;
            mem_wren    = cpu_we;
        end else if (!reset && owner == OWN_DBG) begin
            mem_address = dbg_addr;
            mem_data    = dbg_wdata;
            mem_wren    = dbg_we;
        end
    end

    assign cpu_gnt    = !reset && (owner == OWN_CPU);
    assign dbg_gnt    = !reset && (owner == OWN_DBG);
    assign cpu_rvalid = !reset && (resp == OWN_CPU);
    assign dbg_rvalid = !reset && (resp == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_q : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_rdata_q;
    assign busy       = !reset && ((owner != OWN_NONE) || (resp != OWN_NONE));

endmodule
